// File: rtl/slices_acc_pkg.sv
// rtl/slices_acc_pkg.sv - shared types and helpers for the sliced accumulator array
package slices_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int sum_width(input int wb, input int in_w);
    return wb + $clog2(in_w);
  endfunction

  // Counter must hold tile numbers 1..max_tiles.
  function automatic int cnt_width(input int max_tiles);
    return $clog2(max_tiles + 1);
  endfunction

  // Operands arrive pre-extended to 64 bits; result is {saturated, clamped value}.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int q_w, input bit is_signed);
    logic signed [63:0] s, hi, lo;
    s = signed'(a) + signed'(b);
    if (is_signed) begin
      hi = (64'sd1 <<< (q_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (q_w - 1));
    end else begin
      hi = (64'sd1 <<< q_w) - 64'sd1;
      lo = 64'sd0;
    end
    if (s > hi) return {1'b1, hi};
    if (s < lo) return {1'b1, lo};
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/slices_acc_if.sv
// rtl/slices_acc_if.sv - tile input / result output bundle of the accumulator array
interface slices_acc_if #(
  parameter int N_CH = 64,
  parameter int IN_W = 256,
  parameter int WB   = 4,
  parameter int Q_W  = 20
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [IN_W-1:0]          in_array;
  logic [N_CH*IN_W*WB-1:0]  weight_arrays_flat;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CH*Q_W-1:0]      Q_total_flat;
  logic [N_CH-1:0]          sat_flat;
  logic                     tile_overrun;

  modport master (
    output in_valid, in_last, in_array, weight_arrays_flat, out_ready,
    input  in_ready, out_valid, Q_total_flat, sat_flat, tile_overrun
  );

  modport slave (
    input  in_valid, in_last, in_array, weight_arrays_flat, out_ready,
    output in_ready, out_valid, Q_total_flat, sat_flat, tile_overrun
  );
endinterface

// File: rtl/slices_acc_array_tile_sum.sv
// rtl/slices_acc_array_tile_sum.sv - one channel: masked weight sum of a tile, registered on accept
module slice_tile_sum
  import slices_acc_pkg::*;
#(
  parameter int IN_W   = 256,
  parameter int WB     = 4,
  parameter int SUM_W  = 12,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  logic [IN_W-1:0]      i_in,
  input  logic [IN_W*WB-1:0]   i_w,
  output logic [SUM_W-1:0]     o_sum
);
  localparam bit IS_S = (SIGNED != 0);

  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (i_in[i])
        w_sum = w_sum + {{(SUM_W-WB){IS_S && i_w[i*WB+WB-1]}}, i_w[i*WB +: WB]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_sum <= '0;
    else if (i_en)
      r_sum <= w_sum;
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/slices_acc_array.sv
// rtl/slices_acc_array.sv - N_CH-channel tiled saturating MAC array with single-entry output buffer
module slices_acc_array
  import slices_acc_pkg::*;
#(
  parameter int N_CH      = 64,
  parameter int IN_W      = 256,
  parameter int WB        = 4,
  parameter int Q_W       = 20,
  parameter int MAX_TILES = 16,
  parameter int SIGNED    = 0
) (
  input logic         clk,
  input logic         reset,
  slices_acc_if.slave bus
);
  localparam int SUM_W = sum_width(WB, IN_W);
  localparam int CW    = cnt_width(MAX_TILES);
  localparam bit IS_S  = (SIGNED != 0);

  state_t        r_state;
  logic          r_in_ready, r_out_valid, r_ovr_out;
  logic          r_s1_vld, r_s1_last, r_s1_ovr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_tile_no;
  logic          w_accept, w_at_max, w_end, w_release;

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_tile_no = r_cnt + CW'(1);
  assign w_at_max  = (w_tile_no == CW'(MAX_TILES));
  assign w_end     = bus.in_last || w_at_max;
  assign w_release = (r_state == HOLD) && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovr_out   <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_ovr    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_last <= w_end;
        r_s1_ovr  <= w_at_max && !bus.in_last;
        r_cnt     <= w_end ? '0 : w_tile_no;
      end
      case (r_state)
        ACCUM: if (w_accept && w_end) begin
          r_state    <= FLUSH;
          r_in_ready <= 1'b0;
        end
        FLUSH: begin
          r_state     <= HOLD;
          r_out_valid <= 1'b1;
          r_ovr_out   <= r_s1_ovr;
        end
        HOLD: if (bus.out_ready) begin
          r_state     <= ACCUM;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_ovr_out   <= 1'b0;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SUM_W-1:0] w_sum;
    logic [Q_W-1:0]   r_acc, r_q;
    logic             r_sticky, r_sat;
    logic [63:0]      w_acc_ext, w_sum_ext;
    logic [64:0]      w_res;
    logic             w_unused_hi;

    slice_tile_sum #(
      .IN_W(IN_W), .WB(WB), .SUM_W(SUM_W), .SIGNED(SIGNED)
    ) u_sum (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_accept),
      .i_in  (bus.in_array),
      .i_w   (bus.weight_arrays_flat[c*IN_W*WB +: IN_W*WB]),
      .o_sum (w_sum)
    );

    assign w_acc_ext   = {{(64-Q_W){IS_S && r_acc[Q_W-1]}}, r_acc};
    assign w_sum_ext   = {{(64-SUM_W){IS_S && w_sum[SUM_W-1]}}, w_sum};
    assign w_res       = sat_add(w_acc_ext, w_sum_ext, Q_W, IS_S);
    assign w_unused_hi = ^w_res[63:Q_W];

    // S2: fold the registered tile sum in; the last tile lands in the output buffer instead.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_acc    <= '0;
        r_q      <= '0;
        r_sticky <= 1'b0;
        r_sat    <= 1'b0;
      end else begin
        if (r_s1_vld) begin
          if (r_s1_last) begin
            r_q      <= w_res[Q_W-1:0];
            r_sat    <= r_sticky | w_res[64];
            r_acc    <= '0;
            r_sticky <= 1'b0;
          end else begin
            r_acc    <= w_res[Q_W-1:0];
            r_sticky <= r_sticky | w_res[64];
          end
        end
        if (w_release)
          r_sat <= 1'b0;
      end
    end

    assign bus.Q_total_flat[c*Q_W +: Q_W] = r_q;
    assign bus.sat_flat[c]                = r_sat;
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.tile_overrun = r_ovr_out;
endmodule

// File: tb/tb_slices_acc_array.sv
// tb/tb_slices_acc_array.sv - scoreboard bench for slices_acc_array across four configurations
module tb_slices_acc_array;
  import slices_acc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1279:0] q;
    logic [63:0]   sat;
    logic          ovr;
  } exp_t;

  exp_t qa[$], qb[$], qc[$], qd[$];

  slices_acc_if #(.N_CH(64), .IN_W(256), .WB(4), .Q_W(20)) ia ();
  slices_acc_if #(.N_CH(4),  .IN_W(256), .WB(4), .Q_W(12)) ib ();
  slices_acc_if #(.N_CH(4),  .IN_W(256), .WB(4), .Q_W(20)) ic ();
  slices_acc_if #(.N_CH(4),  .IN_W(256), .WB(4), .Q_W(20)) id ();

  slices_acc_array #(.N_CH(64), .Q_W(20)) u_a (.clk(clk), .reset(reset), .bus(ia));
  slices_acc_array #(.N_CH(4),  .Q_W(12)) u_b (.clk(clk), .reset(reset), .bus(ib));
  slices_acc_array #(.N_CH(4),  .SIGNED(1)) u_c (.clk(clk), .reset(reset), .bus(ic));
  slices_acc_array #(.N_CH(4),  .MAX_TILES(4)) u_d (.clk(clk), .reset(reset), .bus(id));

  task automatic chk(input string name, input logic [1279:0] act, input logic [1279:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e, input logic [1279:0] q,
                         input logic [63:0] s, input logic o);
    chk({tag, "_q"}, q, e.q);
    chk({tag, "_sat"}, 1280'(s), 1280'(e.sat));
    chk({tag, "_ovr"}, 1280'(o), 1280'(e.ovr));
  endtask

  function automatic logic [1279:0] qv(input int qw, input int nch,
                                       input longint c0, input longint c1, input longint cr);
    logic [1279:0] r;
    longint v;
    r = '0;
    for (int c = 0; c < nch; c++) begin
      v = (c == 0) ? c0 : (c == 1) ? c1 : cr;
      for (int b = 0; b < qw; b++) r[c*qw+b] = v[b];
    end
    return r;
  endfunction

  function automatic logic [255:0] ones(input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic push(input int d, input logic [1279:0] q, input logic [63:0] s, input logic o);
    exp_t e;
    e.q = q; e.sat = s; e.ovr = o;
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      2: qc.push_back(e);
      default: qd.push_back(e);
    endcase
  endtask

  task automatic send(input int d, input logic [255:0] bits, input logic last);
    logic rdy;
    bit   done;
    done = 0;
    @(negedge clk);
    case (d)
      0: begin ia.in_valid = 1'b1; ia.in_array = bits; ia.in_last = last; end
      1: begin ib.in_valid = 1'b1; ib.in_array = bits; ib.in_last = last; end
      2: begin ic.in_valid = 1'b1; ic.in_array = bits; ic.in_last = last; end
      default: begin id.in_valid = 1'b1; id.in_array = bits; id.in_last = last; end
    endcase
    for (int n = 0; n < 40 && !done; n++) begin
      case (d)
        0: rdy = ia.in_ready;
        1: rdy = ib.in_ready;
        2: rdy = ic.in_ready;
        default: rdy = id.in_ready;
      endcase
      @(posedge clk);
      if (rdy) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: dut %0d in_ready stayed 0, required 1", d);
    end
    @(negedge clk);
    case (d)
      0: ia.in_valid = 1'b0;
      1: ib.in_valid = 1'b0;
      2: ic.in_valid = 1'b0;
      default: id.in_valid = 1'b0;
    endcase
  endtask

  // Monitor: one pop per output handshake, sampled well after the falling edge.
  always begin
    @(negedge clk);
    #2;
    if (ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) begin checks++; errors++; $display("FAIL mon_a: unexpected result, got 1 required 0"); end
      else cmp_out("a", qa.pop_front(), ia.Q_total_flat, ia.sat_flat, ia.tile_overrun);
    end
    if (ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) begin checks++; errors++; $display("FAIL mon_b: unexpected result, got 1 required 0"); end
      else cmp_out("b", qb.pop_front(), 1280'(ib.Q_total_flat), 64'(ib.sat_flat), ib.tile_overrun);
    end
    if (ic.out_valid && ic.out_ready) begin
      if (qc.size() == 0) begin checks++; errors++; $display("FAIL mon_c: unexpected result, got 1 required 0"); end
      else cmp_out("c", qc.pop_front(), 1280'(ic.Q_total_flat), 64'(ic.sat_flat), ic.tile_overrun);
    end
    if (id.out_valid && id.out_ready) begin
      if (qd.size() == 0) begin checks++; errors++; $display("FAIL mon_d: unexpected result, got 1 required 0"); end
      else cmp_out("d", qd.pop_front(), 1280'(id.Q_total_flat), 64'(id.sat_flat), id.tile_overrun);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ia.in_valid = 0; ia.in_last = 0; ia.in_array = '0; ia.out_ready = 1; ia.weight_arrays_flat = '0;
    ib.in_valid = 0; ib.in_last = 0; ib.in_array = '0; ib.out_ready = 1; ib.weight_arrays_flat = '0;
    ic.in_valid = 0; ic.in_last = 0; ic.in_array = '0; ic.out_ready = 1; ic.weight_arrays_flat = '1;
    id.in_valid = 0; id.in_last = 0; id.in_array = '0; id.out_ready = 1; id.weight_arrays_flat = '0;
    for (int i = 0; i < 256; i++) begin
      ia.weight_arrays_flat[i*4 +: 4]         = 4'd1;
      ia.weight_arrays_flat[(256+i)*4 +: 4]   = 4'd15;
      ib.weight_arrays_flat[(256+i)*4 +: 4]   = 4'd15;
      id.weight_arrays_flat[i*4 +: 4]         = 4'd1;
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_q", ia.Q_total_flat, 0);
    chk("rst_sat_ovr", {ia.sat_flat, ia.tile_overrun}, 0);
    reset = 1'b0;

    // Single-tile vector, default configuration
    push(0, qv(20, 64, 256, 3840, 0), 64'd0, 1'b0);
    send(0, '1, 1'b1);
    chk("t1_lat_early", ia.out_valid, 0);
    @(negedge clk);
    chk("t1_lat_valid", ia.out_valid, 1);
    @(negedge clk);
    chk("t1_ready_back", ia.in_ready, 1);

    // Backpressure: result held while a new tile waits
    ia.out_ready = 1'b0;
    push(0, qv(20, 64, 4, 60, 0), 64'd0, 1'b0);
    send(0, ones(4), 1'b1);
    ia.in_valid = 1'b1; ia.in_array = ones(8); ia.in_last = 1'b1;
    push(0, qv(20, 64, 8, 120, 0), 64'd0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_in_ready", ia.in_ready, 0);
      chk("t4_hold_valid", ia.out_valid, 1);
      chk("t4_hold_q", ia.Q_total_flat, qv(20, 64, 4, 60, 0));
      @(negedge clk);
    end
    ia.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rel_valid", ia.out_valid, 0);
    chk("t4_rel_ready", ia.in_ready, 1);
    @(negedge clk);
    chk("t4_held_taken", ia.in_ready, 0);
    ia.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Unsigned saturation at Q_W=12
    push(1, qv(12, 4, 0, 4095, 0), 64'h2, 1'b0);
    send(1, '1, 1'b0);
    send(1, '1, 1'b1);
    repeat (3) @(negedge clk);

    // Signed weights: three tiles of -256
    push(2, qv(20, 4, -768, -768, -768), 64'd0, 1'b0);
    send(2, '1, 1'b0);
    send(2, '1, 1'b0);
    send(2, '1, 1'b1);
    repeat (3) @(negedge clk);

    // MAX_TILES=4: forced termination, then clean vectors
    push(3, qv(20, 4, 32, 0, 0), 64'd0, 1'b1);
    for (int t = 0; t < 4; t++) send(3, ones(8), 1'b0);
    push(3, qv(20, 4, 8, 0, 0), 64'd0, 1'b0);
    send(3, ones(8), 1'b1);
    push(3, qv(20, 4, 32, 0, 0), 64'd0, 1'b0);
    for (int t = 0; t < 3; t++) send(3, ones(8), 1'b0);
    send(3, ones(8), 1'b1);
    repeat (3) @(negedge clk);

    // Reset mid-vector discards the partial sum
    send(0, ones(100), 1'b0);
    send(0, ones(100), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rst_in_ready", ia.in_ready, 1);
    chk("t6_rst_out_valid", ia.out_valid, 0);
    chk("t6_rst_q", ia.Q_total_flat, 0);
    @(negedge clk);
    reset = 1'b0;
    push(0, qv(20, 64, 7, 105, 0), 64'd0, 1'b0);
    send(0, ones(7), 1'b1);
    repeat (4) @(negedge clk);

    chk("queues_empty", qa.size() + qb.size() + qc.size() + qd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
